// File: rtl/cache_pkg.sv
// Shared geometry, state encoding and load/store formatting helpers for the
// 2-way write-back cache controller.
package cache_pkg;

  localparam int WAYS        = 2;
  localparam int SETS        = 8;
  localparam int BLOCK_WORDS = 32;
  localparam int OFFSET_W    = 7;
  localparam int SET_W       = 3;
  localparam int TAG_W       = 22;
  localparam int WORD_W      = 5;
  localparam int SRAM_AW     = SET_W + 1 + WORD_W;

  localparam int LD_LB  = 0;
  localparam int LD_LH  = 1;
  localparam int LD_LW  = 2;
  localparam int LD_LBU = 3;
  localparam int LD_LHU = 4;

  localparam int ST_SB = 0;
  localparam int ST_SH = 1;
  localparam int ST_SW = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_READ,
    S_WB_WRITE,
    S_FETCH,
    S_FILL,
    S_ACCESS,
    S_RESP
  } state_t;

  // Extract and extend the addressed byte/half from a full SRAM word.
  function automatic logic [31:0] load_format(input logic [31:0] w,
                                              input logic [4:0]  ld,
                                              input logic [1:0]  off);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = w >> {off, 3'b000};
    b = shifted[7:0];
    h = off[1] ? w[31:16] : w[15:0];
    load_format = w;
    if (ld[LD_LB])       load_format = {{24{b[7]}}, b};
    else if (ld[LD_LH])  load_format = {{16{h[15]}}, h};
    else if (ld[LD_LBU]) load_format = {24'd0, b};
    else if (ld[LD_LHU]) load_format = {16'd0, h};
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] st,
                                            input logic [1:0] off);
    store_mask = 4'b0000;
    if (st[ST_SW])      store_mask = 4'b1111;
    else if (st[ST_SH]) store_mask = off[1] ? 4'b1100 : 4'b0011;
    else if (st[ST_SB]) store_mask = 4'b0001 << off;
  endfunction

  // Replicate the store operand so every enabled lane sees its byte.
  function automatic logic [31:0] store_data(input logic [2:0]  st,
                                             input logic [31:0] d);
    store_data = d;
    if (st[ST_SB])      store_data = {4{d[7:0]}};
    else if (st[ST_SH]) store_data = {2{d[15:0]}};
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag/valid/dirty/LRU state for every set and way, with hit compare and
// victim selection for the currently presented address.
module cache_tag_store
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [SET_W-1:0] lookup_set,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             cache_hit,
  output logic             hit_way,
  output logic             victim_way,
  output logic             victim_dirty,
  output logic [TAG_W-1:0] victim_tag,
  input  logic             fill_en,
  input  logic             touch_en,
  input  logic             touch_dirty,
  input  logic [SET_W-1:0] wr_set,
  input  logic             wr_way,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [WAYS-1:0]  valid_reg [SETS];
  logic [WAYS-1:0]  dirty_reg [SETS];
  logic [SETS-1:0]  lru_reg;  // bit s holds the least-recently-used way of set s
  logic [TAG_W-1:0] tag_mem [SETS][WAYS];
  logic [WAYS-1:0]  match;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_match
      assign match[gi] = valid_reg[lookup_set][gi] &&
                         (tag_mem[lookup_set][gi] == lookup_tag);
    end
  endgenerate

  assign cache_hit = req & (|match);
  assign hit_way   = ~match[0];

  always_comb begin
    if (!valid_reg[lookup_set][0])      victim_way = 1'b0;
    else if (!valid_reg[lookup_set][1]) victim_way = 1'b1;
    else                                victim_way = lru_reg[lookup_set];
  end

  assign victim_dirty = valid_reg[lookup_set][victim_way] &
                        dirty_reg[lookup_set][victim_way];
  assign victim_tag   = tag_mem[lookup_set][victim_way];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
      end
      lru_reg <= '0;
    end else begin
      if (fill_en) begin
        valid_reg[wr_set][wr_way] <= 1'b1;
        dirty_reg[wr_set][wr_way] <= 1'b0;
      end
      if (touch_en) begin
        lru_reg[wr_set] <= ~wr_way;
        if (touch_dirty) dirty_reg[wr_set][wr_way] <= 1'b1;
      end
    end
  end

  // Tags need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (fill_en) tag_mem[wr_set][wr_way] <= wr_tag;
  end

endmodule

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate cache controller: request FSM, line buffer and
// byte-lane datapath in front of four external 512x8 data SRAMs.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [4:0]  loadcntrl,
  input  logic [2:0]  storecntrl,
  output logic [31:0] dout,
  output logic        cache_rdy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_ren,
  output logic        mem_wen,
  input  logic [31:0] mem_dout,
  output logic [8:0]  cell_0_addr,
  output logic [7:0]  cell_0_din,
  output logic        cell_0_wen,
  output logic        cell_0_sense_en,
  input  logic [7:0]  cell_0_dout,
  output logic [8:0]  cell_1_addr,
  output logic [7:0]  cell_1_din,
  output logic        cell_1_wen,
  output logic        cell_1_sense_en,
  input  logic [7:0]  cell_1_dout,
  output logic [8:0]  cell_2_addr,
  output logic [7:0]  cell_2_din,
  output logic        cell_2_wen,
  output logic        cell_2_sense_en,
  input  logic [7:0]  cell_2_dout,
  output logic [8:0]  cell_3_addr,
  output logic [7:0]  cell_3_din,
  output logic        cell_3_wen,
  output logic        cell_3_sense_en,
  input  logic [7:0]  cell_3_dout
);

  state_t             state_reg, state_next;
  logic [5:0]         cnt_reg, cnt_next;
  logic [5:0]         cnt_prev;
  logic [31:0]        addr_reg, din_reg, dout_reg;
  logic [4:0]         ld_reg;
  logic [2:0]         st_reg;
  logic               store_reg, way_reg;
  logic [TAG_W-1:0]   vtag_reg;
  logic [31:0]        buf_mem [BLOCK_WORDS];

  logic               cache_hit, hit_way, victim_way, victim_dirty;
  logic [TAG_W-1:0]   victim_tag;
  logic               accept, fill_en, touch_en, touch_dirty, dout_we;
  logic               buf_we;
  logic [WORD_W-1:0]  buf_waddr;
  logic [31:0]        buf_wdata;
  logic [SRAM_AW-1:0] cell_addr;
  logic [31:0]        cell_wdata, cell_rdata;
  logic [3:0]         cell_wen;
  logic               sense_en;
  logic [SET_W-1:0]   set_reg;
  logic [TAG_W-1:0]   tag_reg;

  assign set_reg    = addr_reg[9:7];
  assign tag_reg    = addr_reg[31:10];
  assign cnt_prev   = cnt_reg - 6'd1;
  assign cell_rdata = {cell_3_dout, cell_2_dout, cell_1_dout, cell_0_dout};

  cache_tag_store u_tags (
    .clk          (clk),
    .rst          (rst),
    .req          (ren | wen),
    .lookup_set   (addr[9:7]),
    .lookup_tag   (addr[31:10]),
    .cache_hit    (cache_hit),
    .hit_way      (hit_way),
    .victim_way   (victim_way),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .fill_en      (fill_en),
    .touch_en     (touch_en),
    .touch_dirty  (touch_dirty),
    .wr_set       (set_reg),
    .wr_way       (way_reg),
    .wr_tag       (tag_reg)
  );

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    accept      = 1'b0;
    fill_en     = 1'b0;
    touch_en    = 1'b0;
    touch_dirty = 1'b0;
    dout_we     = 1'b0;
    buf_we      = 1'b0;
    buf_waddr   = '0;
    buf_wdata   = '0;
    mem_addr    = '0;
    mem_din     = '0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    cell_addr   = '0;
    cell_wdata  = '0;
    cell_wen    = 4'b0000;
    sense_en    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (ren | wen) begin
          accept   = 1'b1;
          cnt_next = '0;
          if (cache_hit)         state_next = S_ACCESS;
          else if (victim_dirty) state_next = S_WB_READ;
          else                   state_next = S_FETCH;
        end
      end
      S_WB_READ: begin
        // Issue reads on counts 0..31; SRAM data lands one count later.
        if (!cnt_reg[5]) begin
          sense_en  = 1'b1;
          cell_addr = {set_reg, way_reg, cnt_reg[4:0]};
        end
        if (cnt_reg != 6'd0) begin
          buf_we    = 1'b1;
          buf_waddr = cnt_prev[4:0];
          buf_wdata = cell_rdata;
        end
        if (cnt_reg == 6'd32) begin
          state_next = S_WB_WRITE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 6'd1;
        end
      end
      S_WB_WRITE: begin
        mem_wen  = 1'b1;
        mem_addr = {vtag_reg, set_reg, cnt_reg[4:0], 2'b00};
        mem_din  = buf_mem[cnt_reg[4:0]];
        if (cnt_reg == 6'd31) begin
          state_next = S_FETCH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 6'd1;
        end
      end
      S_FETCH: begin
        if (!cnt_reg[5]) begin
          mem_ren  = 1'b1;
          mem_addr = {tag_reg, set_reg, cnt_reg[4:0], 2'b00};
        end
        if (cnt_reg != 6'd0) begin
          buf_we    = 1'b1;
          buf_waddr = cnt_prev[4:0];
          buf_wdata = mem_dout;
        end
        if (cnt_reg == 6'd32) begin
          state_next = S_FILL;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 6'd1;
        end
      end
      S_FILL: begin
        cell_wen   = 4'b1111;
        cell_addr  = {set_reg, way_reg, cnt_reg[4:0]};
        cell_wdata = buf_mem[cnt_reg[4:0]];
        if (cnt_reg == 6'd31) begin
          fill_en    = 1'b1;
          state_next = S_ACCESS;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 6'd1;
        end
      end
      S_ACCESS: begin
        cell_addr = {set_reg, way_reg, addr_reg[6:2]};
        touch_en  = 1'b1;
        if (store_reg) begin
          touch_dirty = 1'b1;
          cell_wen    = store_mask(st_reg, addr_reg[1:0]);
          cell_wdata  = store_data(st_reg, din_reg);
          state_next  = S_IDLE;
        end else begin
          sense_en   = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        dout_we    = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      din_reg   <= '0;
      ld_reg    <= '0;
      st_reg    <= '0;
      store_reg <= 1'b0;
      way_reg   <= 1'b0;
      vtag_reg  <= '0;
      dout_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg  <= addr;
        din_reg   <= din;
        ld_reg    <= loadcntrl;
        st_reg    <= storecntrl;
        store_reg <= wen;
        way_reg   <= cache_hit ? hit_way : victim_way;
        vtag_reg  <= victim_tag;
      end
      if (dout_we) dout_reg <= load_format(cell_rdata, ld_reg, addr_reg[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[buf_waddr] <= buf_wdata;
  end

  assign dout      = dout_reg;
  assign cache_rdy = (state_reg == S_IDLE);

  assign cell_0_addr = cell_addr;
  assign cell_1_addr = cell_addr;
  assign cell_2_addr = cell_addr;
  assign cell_3_addr = cell_addr;
  assign cell_0_din  = cell_wdata[7:0];
  assign cell_1_din  = cell_wdata[15:8];
  assign cell_2_din  = cell_wdata[23:16];
  assign cell_3_din  = cell_wdata[31:24];
  assign cell_0_wen  = cell_wen[0];
  assign cell_1_wen  = cell_wen[1];
  assign cell_2_wen  = cell_wen[2];
  assign cell_3_wen  = cell_wen[3];
  assign cell_0_sense_en = sense_en;
  assign cell_1_sense_en = sense_en;
  assign cell_2_sense_en = sense_en;
  assign cell_3_sense_en = sense_en;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural memory and byte-lane SRAMs plus a
// scoreboard of expected per-request latency, load data and memory traffic.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ren = 1'b0, wen = 1'b0;
  logic [31:0] addr = '0, din = '0;
  logic [4:0]  loadcntrl = '0;
  logic [2:0]  storecntrl = '0;
  logic [31:0] dout;
  logic        cache_rdy;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_ren, mem_wen;
  logic [3:0][8:0] c_addr;
  logic [3:0][7:0] c_din;
  logic [3:0][7:0] c_dout;
  logic [3:0]      c_wen, c_sense;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst), .ren(ren), .wen(wen), .addr(addr), .din(din),
    .loadcntrl(loadcntrl), .storecntrl(storecntrl), .dout(dout),
    .cache_rdy(cache_rdy), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_dout(mem_dout),
    .cell_0_addr(c_addr[0]), .cell_0_din(c_din[0]), .cell_0_wen(c_wen[0]),
    .cell_0_sense_en(c_sense[0]), .cell_0_dout(c_dout[0]),
    .cell_1_addr(c_addr[1]), .cell_1_din(c_din[1]), .cell_1_wen(c_wen[1]),
    .cell_1_sense_en(c_sense[1]), .cell_1_dout(c_dout[1]),
    .cell_2_addr(c_addr[2]), .cell_2_din(c_din[2]), .cell_2_wen(c_wen[2]),
    .cell_2_sense_en(c_sense[2]), .cell_2_dout(c_dout[2]),
    .cell_3_addr(c_addr[3]), .cell_3_din(c_din[3]), .cell_3_wen(c_wen[3]),
    .cell_3_sense_en(c_sense[3]), .cell_3_dout(c_dout[3])
  );

  // Main memory: unwritten word reads back its own byte address.
  logic [31:0] mem_store [int unsigned];
  always @(posedge clk) begin
    if (mem_ren) mem_dout <= mem_store.exists(mem_addr) ? mem_store[mem_addr] : mem_addr;
    if (mem_wen) mem_store[mem_addr] = mem_din;
  end

  logic [7:0] sram [4][512];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (c_wen[k])   sram[k][c_addr[k]] <= c_din[k];
      if (c_sense[k]) c_dout[k] <= sram[k][c_addr[k]];
    end
  end

  logic [31:0] rd_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  always @(negedge clk) begin
    if (mem_ren) rd_q.push_back(mem_addr);
    if (mem_wen) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_din);
    end
  end

  typedef struct {
    string       name;
    int          low;
    logic [31:0] dout;
    bit          chk_dout;
    int          rd_n;
    logic [31:0] rd_base;
    int          wr_n;
    logic [31:0] wr_base;
    logic [31:0] wr_first;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request, wait for cache_rdy to return, then score it.
  task automatic run_req(input string name, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] lc, input logic [2:0] sc,
                         input int exp_low, input bit chk, input logic [31:0] exp_dout,
                         input int rn, input logic [31:0] rb,
                         input int wn, input logic [31:0] wb, input logic [31:0] wf);
    exp_t e;
    int low;
    e = '{name, exp_low, exp_dout, chk, rn, rb, wn, wb, wf};
    sb.push_back(e);
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    ren = r; wen = w; addr = a; din = d; loadcntrl = lc; storecntrl = sc;
    @(posedge clk); #1;
    ren = 1'b0; wen = 1'b0;
    low = 0;
    while (low < 1000) begin
      @(negedge clk);
      if (cache_rdy) break;
      low++;
    end
    e = sb.pop_front();
    check({e.name, " low"}, low, e.low);
    if (e.chk_dout) check({e.name, " dout"}, dout, e.dout);
    check({e.name, " rd_n"}, rd_q.size(), e.rd_n);
    check({e.name, " wr_n"}, wa_q.size(), e.wr_n);
    for (int i = 0; i < rd_q.size() && i < e.rd_n; i++)
      check({e.name, " rd_addr"}, rd_q[i], e.rd_base + 4 * i);
    for (int i = 0; i < wa_q.size() && i < e.wr_n; i++) begin
      check({e.name, " wr_addr"}, wa_q[i], e.wr_base + 4 * i);
      check({e.name, " wr_data"}, wd_q[i], (i == 0) ? e.wr_first : e.wr_base + 4 * i);
    end
    $display("txn %s addr=0x%08h low=%0d dout=0x%08h rd=%0d wr=%0d",
             e.name, a, low, dout, rd_q.size(), wa_q.size());
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  localparam logic [4:0] LB = 5'b00001, LH = 5'b00010, LW = 5'b00100,
                         LBU = 5'b01000, LHU = 5'b10000;
  localparam logic [2:0] SB = 3'b001, SH = 3'b010, SW = 3'b100;

  initial begin
    #2;
    check("rst cache_rdy", cache_rdy, 1'b1);
    check("rst dout", dout, 32'h0);
    check("rst mem_strobes", {mem_ren, mem_wen}, 2'b00);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst cell_strobes", {c_wen, c_sense}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_req("lw0_miss", 1, 0, 32'h0, 0, LW, 0, 67, 1, 32'h0, 32, 32'h0, 0, 0, 0);
    run_req("lw4_hit", 1, 0, 32'h4, 0, LW, 0, 2, 1, 32'h4, 0, 0, 0, 0, 0);
    run_req("lw8_hit", 1, 0, 32'h8, 0, LW, 0, 2, 1, 32'h8, 0, 0, 0, 0, 0);
    run_req("sw1000_miss", 0, 1, 32'h1000, 32'hDEADBEEF, 0, SW, 66, 0, 0, 32, 32'h1000, 0, 0, 0);
    run_req("lw1000_hit", 1, 0, 32'h1000, 0, LW, 0, 2, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    run_req("lwC_hit", 1, 0, 32'hC, 0, LW, 0, 2, 1, 32'hC, 0, 0, 0, 0, 0);
    run_req("lw2000_evict", 1, 0, 32'h2000, 0, LW, 0, 132, 1, 32'h2000,
            32, 32'h2000, 32, 32'h1000, 32'hDEADBEEF);
    run_req("lw10_hit", 1, 0, 32'h10, 0, LW, 0, 2, 1, 32'h10, 0, 0, 0, 0, 0);
    run_req("lw14_hit", 1, 0, 32'h14, 0, LW, 0, 2, 1, 32'h14, 0, 0, 0, 0, 0);
    run_req("lw1000_refetch", 1, 0, 32'h1000, 0, LW, 0, 67, 1, 32'hDEADBEEF,
            32, 32'h1000, 0, 0, 0);

    do_reset();
    run_req("sb3_miss", 0, 1, 32'h3, 32'h80, 0, SB, 66, 0, 0, 32, 32'h0, 0, 0, 0);
    run_req("lb3", 1, 0, 32'h3, 0, LB, 0, 2, 1, 32'hFFFFFF80, 0, 0, 0, 0, 0);
    run_req("lbu3", 1, 0, 32'h3, 0, LBU, 0, 2, 1, 32'h00000080, 0, 0, 0, 0, 0);
    run_req("lh2", 1, 0, 32'h2, 0, LH, 0, 2, 1, 32'hFFFF8000, 0, 0, 0, 0, 0);
    run_req("lhu2", 1, 0, 32'h2, 0, LHU, 0, 2, 1, 32'h00008000, 0, 0, 0, 0, 0);
    run_req("sh6_hit", 0, 1, 32'h6, 32'h00001234, 0, SH, 1, 0, 0, 0, 0, 0, 0, 0);
    run_req("lw4_after_sh", 1, 0, 32'h4, 0, LW, 0, 2, 1, 32'h12340004, 0, 0, 0, 0, 0);
    run_req("rw8_as_store", 1, 1, 32'h8, 32'hCAFEF00D, LW, SW, 1, 0, 0, 0, 0, 0, 0, 0);
    run_req("lw8_after_rw", 1, 0, 32'h8, 0, LW, 0, 2, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0);

    // Abort a miss mid-fetch and confirm the line was not left valid.
    ren = 1'b1; addr = 32'h3000; loadcntrl = LW;
    @(posedge clk); #1;
    ren = 1'b0;
    repeat (10) @(negedge clk);
    check("fetch busy", cache_rdy, 1'b0);
    check("fetch mem_ren", mem_ren, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("abort cache_rdy", cache_rdy, 1'b1);
    check("abort mem_ren", mem_ren, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_req("lw3000_remiss", 1, 0, 32'h3000, 0, LW, 0, 67, 1, 32'h3000, 32, 32'h3000, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameters (only these defaults supported): WAYS=2 ways; SETS=8 sets; BLOCK_WORDS=32 words per block (128 B).
REQ-002 One clock; reset is asynchronous and active-low: clk in 1 rising-edge clock; rst in 1 async active-low reset.
REQ-003 ren in 1 load request; wen in 1 store request; addr in 32 byte address; din in 32 store data.
REQ-004 loadcntrl in 5 one-hot: [0]LB [1]LH [2]LW [3]LBU [4]LHU; storecntrl in 3 one-hot: [0]SB [1]SH [2]SW.
REQ-005 dout out 32 load result; cache_rdy out 1 idle/ready.
REQ-006 mem_addr out 32, mem_din out 32, mem_ren out 1, mem_wen out 1, mem_dout in 32: word-wide main-memory port.
REQ-007 cell_k_addr out 9, cell_k_din out 8, cell_k_wen out 1, cell_k_sense_en out 1, cell_k_dout in 8 (k=0..3): data-SRAM byte lane k = bits 8k+7:8k.

Function
REQ-008 Geometry: 2-way set-associative, write-back, write-allocate; offset addr[6:0], set addr[9:7], tag addr[31:10] (22 b).
REQ-009 SRAM word address = {set, way, word index}, shared by all four lanes.
REQ-010 Per set/way: valid, dirty, tag. Per set: LRU bit. Internal combinational cache_hit = (ren|wen) & valid & tag match in either way of addressed set.
REQ-011 cache_rdy=1 only in IDLE. A request is accepted at a rising edge with cache_rdy=1 and ren|wen, and cache_rdy falls at that edge. Requester holds ren/wen/addr/din/cntrl until cache_rdy falls. A request still high when cache_rdy rises is a new request.
REQ-012 ren and wen both high: treated as store.
REQ-013 States: IDLE, WB_READ (SRAM->buffer), WB_WRITE (buffer->mem), FETCH (mem->buffer), FILL (buffer->SRAM), ACCESS, RESP.
REQ-014 Load hit: IDLE->ACCESS (sense_en)->RESP (dout latched)->IDLE; cache_rdy low 2 cycles. Store hit: ACCESS (lane wens)->IDLE; low 1 cycle.
REQ-015 Miss victim: lowest invalid way, else LRU way. Dirty victim -> WB_READ; otherwise -> FETCH.
REQ-016 WB_READ: 33 cycles, 32 pipelined sense_en reads into a 32-word buffer. WB_WRITE: 32 cycles, mem_wen=1, mem_addr={victim tag, set, word, 2'b00} ascending. Then -> FETCH.
REQ-017 FETCH: 33 cycles; mem_ren=1 for 32 cycles at block base+4i ascending; mem_dout captured 1 cycle after issue.
REQ-018 FILL: 32 cycles, all lane wens=1. Then tag written, valid=1, dirty=0, -> ACCESS.
REQ-019 cache_rdy-low totals: clean load miss 67, clean store miss 66, dirty victim adds 65.
REQ-020 Store lane wens: SB lane addr[1:0] with din[7:0]; SH lanes 2*addr[1],+1 with din[15:0]; SW all lanes. Store sets dirty.
REQ-021 Load: LW whole word; LB/LH select by addr[1:0]/addr[1], sign-extended; LBU/LHU zero-extended. Address bits below access size ignored.
REQ-022 Any hit or fill makes the accessed way MRU.
REQ-023 dout holds until the next load completes. mem and cell strobes are 0 outside their named states.

Reset
REQ-024 rst low: valid/dirty/LRU cleared; state IDLE; cache_rdy=1; dout=0; all strobes, addresses and data outputs 0.
REQ-025 Reset mid-miss aborts: no line becomes valid, a partial memory writeback is permitted, SRAM contents are not cleared.

Structure
REQ-026 Package cache_pkg holds geometry constants, field widths, state enum, loadcntrl/storecntrl bit positions.
REQ-027 One sub-module, cache_tag_store: tag/valid/dirty/LRU arrays, hit compare, victim select. FSM, buffer and datapath stay in cache_ctrl. mem_behav (word i initialised to its byte address; read data 1 cycle after mem_ren) and sram_behav (512x8; write on wen; dout registered on sense_en) are bench models only.

Verification
REQ-028 Reset, then LW 0x0 -> miss, mem reads 0x0..0x7C, cache_rdy low 67, dout=0x00000000.
REQ-029 LW 0x4, LW 0x8 -> hits, each low 2, dout 0x4 then 0x8, no mem strobes.
REQ-030 SW 0x1000 = 0xDEADBEEF -> clean miss into set0 way1, low 66. LW 0x1000 -> hit, dout 0xDEADBEEF.
REQ-031 LW 0xC (hit), then LW 0x2000 -> dirty evict of the 0x1000 line: writes 0x1000..0x107C, first word 0xDEADBEEF, then fetch. Low 132, dout=0x00002000. Then LW 0x10 and LW 0x14 hit.
REQ-032 After reset: SB 0x80 at 0x3 -> LB 0x3 = 0xFFFFFF80, LBU 0x3 = 0x00000080, LH 0x2 = 0xFFFF8000.
REQ-033 rst low during FETCH -> cache_rdy=1 at once; re-reading the same address misses.
